// File: rtl/bht_update_unit.sv
// ---------------------------------------------------------------------------
// bht_update_unit
//
// Resolution-side companion to the branch history table. Every prediction
// issued at fetch is queued in program order as {addr, state}. When execute
// resolves the oldest branch, the unit computes the next 2-bit counter value,
// writes it back to the BHT one cycle later and flags a mispredict, which
// also flushes every younger in-flight entry.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   pred_valid/pred_ready   prediction record handshake (fetch side)
//   pred_addr, pred_state   BHT index and counter read at prediction time
//   res_valid/res_ready     resolve handshake (execute side, oldest first)
//   res_taken               actual branch direction
//   wr_en, wr_addr, wr_data registered one-cycle BHT write
//   mispredict, mp_addr     registered one-cycle mispredict pulse and index
//   count                   number of in-flight entries
// ---------------------------------------------------------------------------
module bht_update_unit #(
  parameter int AW    = 10,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pred_valid,
  input  logic [AW-1:0]              pred_addr,
  input  logic [1:0]                 pred_state,
  output logic                       pred_ready,
  input  logic                       res_valid,
  input  logic                       res_taken,
  output logic                       res_ready,
  output logic                       wr_en,
  output logic [AW-1:0]              wr_addr,
  output logic [1:0]                 wr_data,
  output logic                       mispredict,
  output logic [AW-1:0]              mp_addr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0] addr_mem  [DEPTH];
  logic [1:0]    state_mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  logic          push;
  logic          pop;
  logic [AW-1:0] head_addr;
  logic [1:0]    head_state;
  logic [1:0]    res_state;
  logic          res_mp;
  logic [1:0]    push_state;

  // Readiness depends on occupancy only, so a same-cycle pop never frees
  // a slot and a same-cycle push never makes an empty queue resolvable.
  assign pred_ready = (count != CW'(DEPTH));
  assign res_ready  = (count != '0);
  assign push       = pred_valid && pred_ready;
  assign pop        = res_valid && res_ready;

  assign head_addr  = addr_mem[rd_ptr];
  assign head_state = state_mem[rd_ptr];

  // Next counter value for the oldest entry and whether its predicted
  // direction (state[1]) was wrong.
  always_comb begin
    res_state = 2'b00;
    if (res_taken) begin
      res_state = (head_state == 2'b00) ? 2'b01 : 2'b11;
    end else begin
      res_state = (head_state == 2'b11) ? 2'b10 : 2'b00;
    end
  end

  assign res_mp = pop && (res_taken != head_state[1]);

  // A new record takes the freshest counter for its branch: the value being
  // resolved this cycle wins over the write still pending on the BHT port,
  // which in turn wins over the possibly stale value fetch read.
  always_comb begin
    push_state = pred_state;
    if (pop && (pred_addr == head_addr)) begin
      push_state = res_state;
    end else if (wr_en && (wr_addr == pred_addr)) begin
      push_state = wr_data;
    end
  end

  // Queue storage needs no reset. Younger entries of the resolved branch are
  // refreshed with the new counter; on a mispredict these updates and any
  // push land in slots the pointer flush discards anyway.
  always_ff @(posedge clk) begin
    if (pop) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (addr_mem[i] == head_addr) begin
          state_mem[i] <= res_state;
        end
      end
    end
    if (push) begin
      addr_mem[wr_ptr]  <= pred_addr;
      state_mem[wr_ptr] <= push_state;
    end
  end

  // Pointers and occupancy; a mispredict empties the queue by equalising
  // the pointers just past the resolved entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (res_mp) begin
      rd_ptr <= rd_ptr + PW'(1);
      wr_ptr <= rd_ptr + PW'(1);
      count  <= '0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Registered BHT write and mispredict pulses, one cycle after the resolve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 2'b00;
      mispredict <= 1'b0;
      mp_addr    <= '0;
    end else begin
      wr_en      <= pop;
      mispredict <= res_mp;
      if (pop) begin
        wr_addr <= head_addr;
        wr_data <= res_state;
      end
      if (res_mp) begin
        mp_addr <= head_addr;
      end
    end
  end

endmodule
